mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  MEM-stage load/store sequencer between the MIPS pipeline and a handshaked data memory.
//  Accepts one access per instruction and checks alignment.
//  Drives the memory req/gnt/rvalid protocol and stalls the pipeline until the access completes.
//  Lane-selects and byte/half extends load data (little-endian); builds store byte enables.
// PARAMETERS
//  NBITS      32   data and address width
//  TNBITS     2    access-size code width
//  TOUT_CYC   16   watchdog limit: cycles allowed in REQ or WAIT before error
// PORTS
//  i_clk          in   1      clock; all state on rising edge
//  i_reset        in   1      synchronous, active-high reset
//  i_valid        in   1      MEM-stage instruction valid
//  i_load         in   1      instruction is a load
//  i_store        in   1      instruction is a store (load has priority if both are set)
//  i_addr         in   NBITS  byte address
//  i_wdata        in   NBITS  store data, right-aligned
//  i_size         in   TNBITS 00 word, 01 byte, 10 half, 11 illegal
//  i_unsigned     in   1      1 = zero-extend load, 0 = sign-extend load
//  o_stall        out  1      freeze pipeline stages up to and including MEM
//  o_done         out  1      one-cycle pulse: access retired
//  o_rdata        out  NBITS  extended load result; valid when o_done and load
//  o_err_align    out  1      with o_done: misaligned or illegal size, memory not accessed
//  o_err_tout     out  1      with o_done: watchdog expired
//  o_mem_req      out  1      memory request
//  o_mem_we       out  1      1 = write
//  o_mem_addr     out  NBITS  {i_addr[NBITS-1:2], 2'b00}
//  o_mem_wdata    out  NBITS  store data replicated into lanes
//  o_mem_be       out  4      byte enables
//  i_mem_gnt      in   1      request accepted
//  i_mem_rvalid   in   1      read data valid
//  i_mem_rdata    in   NBITS  read word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; o_rdata 0; watchdog counter 0.
//    Reset mid-access abandons it; no o_done is produced.
//  start = i_valid & (i_load | i_store), sampled in IDLE only.
//  FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE:
//   IDLE: on start, latch addr/wdata/size/unsigned/op.
//     Misaligned or illegal -> DONE with err_align. Otherwise -> REQ.
//   REQ: o_mem_req=1; addr/we/be/wdata are held stable from the latched values.
//     gnt & store -> DONE; gnt & load -> WAIT.
//   WAIT: req=0. On rvalid, register extended data into o_rdata -> DONE.
//     rvalid in the same cycle as gnt is not accepted; data is taken in WAIT only.
//   DONE: o_done=1 for one cycle, o_stall=0 -> IDLE. Inputs are ignored in DONE.
//  o_stall = (IDLE & start) | REQ | WAIT  (combinational; covers the accept cycle).
//  Minimum latency: store 2 cycles to o_done; load 3 cycles. Error path: 1 cycle.
//  Alignment: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
//  Store lanes:
//    byte: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}
//    half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}
//    word: be = 1111
//  Load extend:
//    byte: lane = rdata[8*addr[1:0] +: 8]
//    half: lane = rdata[16*addr[1] +: 16]
//    Pad with the lane MSB (signed) or with zeros (unsigned). word: passthrough.
//  Watchdog: counts cycles in REQ/WAIT; cleared on every state change.
//    At TOUT_CYC -> DONE with err_tout, o_mem_req dropped, o_rdata unchanged.
//  Errors leave memory untouched; o_rdata holds its previous value on error.
// STRUCTURE
//  Package mips_mem_pkg: size codes SZ_WORD/SZ_BYTE/SZ_HALF/SZ_ILL,
//    FSM encoding ST_IDLE/ST_REQ/ST_WAIT/ST_DONE, BE_* constants.
//  Sub-module load_lane_extend (combinational): rdata, addr[1:0], size, unsigned -> result.
//    Instantiated once, feeding the WAIT-state capture register.
// TESTING
//  1. lw addr 0x10, gnt after 2 cycles, rvalid 1 later, rdata 0xDEADBEEF ->
//     stall 4 cycles, o_done with o_rdata=0xDEADBEEF.
//  2. lb addr 0x13 signed, rdata 0x80112233 -> o_rdata 0xFFFFFF80;
//     same access with lbu -> 0x00000080.
//  3. sh addr 0x22, wdata 0x0000ABCD, gnt immediately ->
//     be=1100, mem_wdata=0xABCDABCD, o_done 2 cycles after start.
//  4. lw addr 0x06 -> no o_mem_req, o_done+o_err_align next cycle;
//     size 11 gives the same result.
//  5. lh with gnt never asserted -> o_err_tout after TOUT_CYC cycles, stall released.
//  6. i_reset asserted while in WAIT -> all outputs 0 next cycle, no o_done;
//     a later rvalid is ignored.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store sequencer: size codes, FSM states,
// byte-enable patterns and the alignment / lane helpers used by the control path.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_WORD: ok = (addr_lo == 2'b00);
            SZ_HALF: ok = ~addr_lo[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] access_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = BE_NONE;
        case (size)
            SZ_WORD: be = BE_WORD;
            SZ_HALF: be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_BYTE: be = BE_BYTE0 << addr_lo;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Data-memory bus between the sequencer (master) and the memory (slave).
// The master holds req and the address/data/enables stable until gnt is seen;
// read data is accepted on rvalid only in the cycle after the grant or later.
interface mem_access_sequencer_if #(
    parameter int NBITS = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [NBITS-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_lane_extend.sv
// Little-endian lane select and sign/zero extension of a loaded word.
module load_lane_extend
    import mips_mem_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] i_rdata,
    input  logic [1:0]       i_addr_lo,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    output logic [NBITS-1:0] o_result
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        pad_bit;

    always_comb begin
        byte_lane = i_rdata[{i_addr_lo, 3'b000} +: 8];
        half_lane = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        pad_bit   = 1'b0;
        o_result  = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                pad_bit  = ~i_unsigned & byte_lane[7];
                o_result = {{(NBITS-8){pad_bit}}, byte_lane};
            end
            SZ_HALF: begin
                pad_bit  = ~i_unsigned & half_lane[15];
                o_result = {{(NBITS-16){pad_bit}}, half_lane};
            end
            default: o_result = i_rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer: one access per instruction, alignment check,
// req/gnt/rvalid sequencing with a watchdog, and a pipeline stall until retirement.
module mem_access_sequencer
    import mips_mem_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int TNBITS   = 2,
    parameter int TOUT_CYC = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_load,
    input  logic                   i_store,
    input  logic [NBITS-1:0]       i_addr,
    input  logic [NBITS-1:0]       i_wdata,
    input  logic [TNBITS-1:0]      i_size,
    input  logic                   i_unsigned,
    output logic                   o_stall,
    output logic                   o_done,
    output logic [NBITS-1:0]       o_rdata,
    output logic                   o_err_align,
    output logic                   o_err_tout,
    output state_e                 o_dbg_state,
    mem_access_sequencer_if.master mem
);
    localparam int            CW        = $clog2(TOUT_CYC + 1);
    localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NBITS-1:0]    addr_q, addr_d;
    logic [NBITS-1:0]    wdata_q, wdata_d;
    logic [TNBITS-1:0]   size_q, size_d;
    logic                uns_q, uns_d;
    logic                is_load_q, is_load_d;
    logic                err_align_q, err_align_d;
    logic                err_tout_q, err_tout_d;
    logic [NBITS-1:0]    rdata_q, rdata_d;

    logic                start;
    logic                aligned;
    logic                tout_hit;
    logic [NBITS-1:0]    ext_result;
    logic [NBITS-1:0]    lane_wdata;

    assign start    = i_valid & (i_load | i_store);
    assign aligned  = is_aligned(i_size[1:0], i_addr[1:0]);
    assign tout_hit = (cnt_q == TOUT_LAST);

    load_lane_extend #(.NBITS(NBITS)) u_extend (
        .i_rdata    (mem.mem_rdata),
        .i_addr_lo  (addr_q[1:0]),
        .i_size     (size_q[1:0]),
        .i_unsigned (uns_q),
        .o_result   (ext_result)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            is_load_q   <= 1'b0;
            err_align_q <= 1'b0;
            err_tout_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            is_load_q   <= is_load_d;
            err_align_q <= err_align_d;
            err_tout_q  <= err_tout_d;
            rdata_q     <= rdata_d;
        end
    end

    // Watchdog restarts on every state change; a grant or rvalid on the last
    // allowed cycle still wins over the timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        is_load_d   = is_load_q;
        err_align_d = err_align_q;
        err_tout_d  = err_tout_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = i_addr;
                    wdata_d     = i_wdata;
                    size_d      = i_size;
                    uns_d       = i_unsigned;
                    is_load_d   = i_load;
                    err_align_d = ~aligned;
                    err_tout_d  = 1'b0;
                    cnt_d       = '0;
                    state_d     = aligned ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = is_load_q ? ST_WAIT : ST_DONE;
                end else if (tout_hit) begin
                    cnt_d      = '0;
                    err_tout_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    rdata_d = ext_result;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (tout_hit) begin
                    cnt_d      = '0;
                    err_tout_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        lane_wdata = wdata_q;
        case (size_q[1:0])
            SZ_BYTE: lane_wdata = {(NBITS/8){wdata_q[7:0]}};
            SZ_HALF: lane_wdata = {(NBITS/16){wdata_q[15:0]}};
            default: lane_wdata = wdata_q;
        endcase
    end

    // Bus outputs are only non-zero while requesting, so memory never sees an
    // enable outside a real access.
    always_comb begin
        o_stall       = ((state_q == ST_IDLE) & start) | (state_q == ST_REQ) | (state_q == ST_WAIT);
        o_done        = (state_q == ST_DONE);
        o_err_align   = (state_q == ST_DONE) & err_align_q;
        o_err_tout    = (state_q == ST_DONE) & err_tout_q;
        o_rdata       = rdata_q;
        o_dbg_state   = state_q;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_be    = BE_NONE;
        if (state_q == ST_REQ) begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = ~is_load_q;
            mem.mem_addr  = {addr_q[NBITS-1:2], 2'b00};
            mem.mem_be    = access_be(size_q[1:0], addr_q[1:0]);
            mem.mem_wdata = is_load_q ? '0 : lane_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: loads, stores, alignment errors,
// watchdog timeout and reset in the middle of an access.
module tb_mem_access_sequencer;
    import mips_mem_pkg::*;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    logic        i_load;
    logic        i_store;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_err_align;
    logic        o_err_tout;
    state_e      dbg_state;

    int checks;
    int errors;
    int cnt;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    mem_access_sequencer_if #(.NBITS(32)) mem ();

    mem_access_sequencer #(.NBITS(32), .TNBITS(2), .TOUT_CYC(16)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_load      (i_load),
        .i_store     (i_store),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_err_align (o_err_align),
        .o_err_tout  (o_err_tout),
        .o_dbg_state (dbg_state),
        .mem         (mem.master)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        i_valid    = 1'b1;
        i_load     = ld;
        i_store    = st;
        i_addr     = addr;
        i_wdata    = wdata;
        i_size     = size;
        i_unsigned = uns;
    endtask

    task automatic drop_valid();
        i_valid = 1'b0;
        i_load  = 1'b0;
        i_store = 1'b0;
    endtask

    // Load with immediate grant; junk rvalid in the grant cycle must be ignored.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] word, input logic [31:0] exp);
        exp_q.push_back(exp);
        issue(1'b1, 1'b0, addr, 32'h0, size, uns);
        next_cycle();
        drop_valid();
        mem.mem_gnt    = 1'b1;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = 32'h5555AAAA;
        @(negedge i_clk);
        chk({tag, "_addr"}, mem.mem_addr, {addr[31:2], 2'b00});
        next_cycle();
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = word;
        next_cycle();
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'h0;
        @(negedge i_clk);
        exp_v = exp_q.pop_front();
        chk({tag, "_done"}, {31'b0, o_done}, 32'd1);
        chk({tag, "_rdata"}, o_rdata, exp_v);
        next_cycle();
    endtask

    // Store with immediate grant; checks lanes in the REQ cycle and done after it.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(1'b0, 1'b1, addr, wdata, size, 1'b0);
        next_cycle();
        drop_valid();
        mem.mem_gnt = 1'b1;
        @(negedge i_clk);
        chk({tag, "_we"}, {31'b0, mem.mem_we}, 32'd1);
        chk({tag, "_be"}, {28'b0, mem.mem_be}, {28'b0, exp_be});
        chk({tag, "_wdata"}, mem.mem_wdata, exp_wd);
        chk({tag, "_addr"}, mem.mem_addr, {addr[31:2], 2'b00});
        next_cycle();
        mem.mem_gnt = 1'b0;
        @(negedge i_clk);
        chk({tag, "_done"}, {31'b0, o_done}, 32'd1);
        next_cycle();
    endtask

    // Misaligned/illegal access: no request, done with err_align next cycle.
    task automatic do_misalign(input string tag, input logic [31:0] addr, input logic [1:0] size,
                               input logic [31:0] prev_rdata);
        issue(1'b1, 1'b0, addr, 32'h0, size, 1'b0);
        @(negedge i_clk);
        chk({tag, "_stall"}, {31'b0, o_stall}, 32'd1);
        chk({tag, "_noreq0"}, {31'b0, mem.mem_req}, 32'd0);
        next_cycle();
        drop_valid();
        @(negedge i_clk);
        chk({tag, "_done"}, {30'b0, o_done, o_err_align}, 32'd3);
        chk({tag, "_noreq1"}, {31'b0, mem.mem_req}, 32'd0);
        chk({tag, "_rdata_hold"}, o_rdata, prev_rdata);
        next_cycle();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        i_reset        = 1'b1;
        i_valid        = 1'b0;
        i_load         = 1'b0;
        i_store        = 1'b0;
        i_addr         = 32'h0;
        i_wdata        = 32'h0;
        i_size         = 2'b00;
        i_unsigned     = 1'b0;
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'h0;
        repeat (3) next_cycle();
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_outs", {27'b0, o_stall, o_done, o_err_align, o_err_tout, mem.mem_req}, 32'd0);
        chk("rst_rdata", o_rdata, 32'h0);
        next_cycle();

        // lw 0x10: grant on the second REQ cycle, rvalid one cycle later.
        cnt = 0;
        issue(1'b1, 1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0);
        @(negedge i_clk);
        cnt += int'(o_stall);
        next_cycle();
        drop_valid();
        @(negedge i_clk);
        cnt += int'(o_stall);
        chk("lw_req", {31'b0, mem.mem_req}, 32'd1);
        chk("lw_addr", mem.mem_addr, 32'h10);
        next_cycle();
        mem.mem_gnt = 1'b1;
        @(negedge i_clk);
        cnt += int'(o_stall);
        next_cycle();
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = 32'hDEADBEEF;
        @(negedge i_clk);
        cnt += int'(o_stall);
        chk("lw_wait_noreq", {31'b0, mem.mem_req}, 32'd0);
        next_cycle();
        mem.mem_rvalid = 1'b0;
        @(negedge i_clk);
        cnt += int'(o_stall);
        chk("lw_done", {30'b0, o_done, o_stall}, 32'd2);
        chk("lw_rdata", o_rdata, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(cnt), 32'd4);
        next_cycle();

        do_load("lb_s", 32'h13, SZ_BYTE, 1'b0, 32'h80112233, 32'hFFFFFF80);
        do_load("lbu", 32'h13, SZ_BYTE, 1'b1, 32'h80112233, 32'h00000080);
        do_load("lb_b1", 32'h11, SZ_BYTE, 1'b0, 32'h80112233, 32'h00000022);
        do_load("lh_s", 32'h12, SZ_HALF, 1'b0, 32'h80112233, 32'hFFFF8011);
        do_load("lhu_lo", 32'h10, SZ_HALF, 1'b1, 32'h8011F233, 32'h0000F233);

        do_store("sh", 32'h22, 32'h0000ABCD, SZ_HALF, 4'b1100, 32'hABCDABCD);
        do_store("sb", 32'h01, 32'h0000005A, SZ_BYTE, 4'b0010, 32'h5A5A5A5A);
        do_store("sw", 32'h24, 32'h12345678, SZ_WORD, 4'b1111, 32'h12345678);

        do_misalign("lw_mis", 32'h06, SZ_WORD, 32'h0000F233);
        do_misalign("size_ill", 32'h00, SZ_ILL, 32'h0000F233);
        do_misalign("lh_mis", 32'h03, SZ_HALF, 32'h0000F233);

        // lh without any grant: watchdog retires it after 16 REQ cycles.
        cnt = 0;
        issue(1'b1, 1'b0, 32'h10, 32'h0, SZ_HALF, 1'b0);
        next_cycle();
        drop_valid();
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            cnt += int'(mem.mem_req & o_stall);
            next_cycle();
        end
        @(negedge i_clk);
        chk("tout_req_cycles", 32'(cnt), 32'd16);
        chk("tout_done", {28'b0, o_done, o_err_tout, o_stall, mem.mem_req}, 32'b1100);
        chk("tout_rdata_hold", o_rdata, 32'h0000F233);
        next_cycle();
        @(negedge i_clk);
        chk("tout_idle", 32'(dbg_state), 32'(ST_IDLE));
        next_cycle();

        // Reset while in WAIT abandons the access.
        issue(1'b1, 1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0);
        next_cycle();
        drop_valid();
        mem.mem_gnt = 1'b1;
        next_cycle();
        mem.mem_gnt = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_wait", 32'(dbg_state), 32'(ST_WAIT));
        i_reset = 1'b1;
        next_cycle();
        @(negedge i_clk);
        chk("rst_mid_outs", {27'b0, o_stall, o_done, o_err_align, o_err_tout, mem.mem_req}, 32'd0);
        chk("rst_mid_rdata", o_rdata, 32'h0);
        next_cycle();
        i_reset        = 1'b0;
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = 32'hCAFEF00D;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            cnt += int'(o_done);
            next_cycle();
        end
        mem.mem_rvalid = 1'b0;
        @(negedge i_clk);
        chk("late_rvalid_nodone", 32'(cnt), 32'd0);
        chk("late_rvalid_rdata", o_rdata, 32'h0);
        chk("late_rvalid_state", 32'(dbg_state), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
